fetch_seq: RTL and testbench
============================

# fetch_seq

Parametrised program-counter and fetch sequencer, successor to the single-program PC unit. Sequences through `NUM_PROGS` programs held in one instruction memory, each with its own start and end address, and supports absolute and conditional relative branches, a stall input and an optional hardware call/return stack. It sits at the front of the processor and drives the instruction-memory address; DONE/All_done go to the testbench and top level.

## Interface

Parameters:
- `PC_W`, 16, PC and Target width.
- `NUM_PROGS`, 3, number of programs in the sequence (1..8).
- `RAS_DEPTH`, 4, return-stack entries, power of two; used only with `FETCH_RAS_EN`.

Ports:
- `CLK` in 1: clock. All state changes on posedge only.
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: launch the next program in the sequence.
- `Stall` in 1: hold PC this cycle.
- `Branch_abs` in 1: PC <= Target.
- `Branch_rel_z` in 1: PC <= PC+Target if ALU_zero.
- `Branch_rel_nz` in 1: PC <= PC+Target if !ALU_zero.
- `ALU_zero` in 1: ALU zero flag.
- `Call` in 1: push PC+1, PC <= Target (RAS build only).
- `Ret` in 1: pop, PC <= popped value (RAS build only).
- `Target` in PC_W: branch target or offset.
- `PC` out PC_W: program counter.
- `DONE` out 1: current program has finished.
- `All_done` out 1: every program has finished.
- `Prog_idx` out $clog2(NUM_PROGS+1): index of the current/next program.
- `Ras_err` out 1: sticky overflow or underflow flag (RAS build only; tied 0 otherwise).

## Operation

- FSM states are IDLE, RUN and HALT.
- Reset: state IDLE, PC=0, DONE=0, All_done=0, Prog_idx=0, RAS pointer=0, Ras_err=0.
- IDLE/HALT with Start=1 and Prog_idx<NUM_PROGS:
  - PC <= PROG_START[Prog_idx], DONE <= 0, state RUN.
- HALT with Start=1 and All_done=1: ignored.
- RUN with Start=1: ignored.
- RUN, in descending priority per cycle:
  1. PC == PROG_END[Prog_idx]: DONE <= 1, Prog_idx <= Prog_idx+1, state HALT, PC held. All_done <= 1 if Prog_idx+1 == NUM_PROGS.
  2. Stall: PC held. All branch inputs are ignored and not queued.
  3. Branch_abs: PC <= Target.
  4. Call (RAS): push PC+1, PC <= Target.
  5. Ret (RAS): pop, PC <= popped value.
  6. Branch_rel_z && ALU_zero: PC <= PC+Target.
  7. Branch_rel_nz && !ALU_zero: PC <= PC+Target.
  8. Otherwise: PC <= PC+1.
- Arithmetic:
  - All additions are modulo 2^PC_W.
  - Target is a two's-complement offset for relative branches, so a negative offset wraps.
  - PC+1 at all-ones wraps to 0.
- Return stack:
  - Push onto a full stack overwrites the oldest entry (circular) and sets Ras_err.
  - Pop from an empty stack yields PC+1, pointer unchanged, and sets Ras_err.
  - Ras_err clears only on Reset.
- Reset has priority over everything, including mid-program and during Stall.

## Timing

- PC is registered. A branch, call or ret sampled at edge N gives the new PC after edge N, with zero bubbles.
- DONE rises one cycle after the cycle in which PC equals PROG_END. PC stays at PROG_END while in HALT.
- Start-to-first-PC latency is 1 cycle.
- Start in the same cycle as the end match is ignored (state is still RUN).
- Start while Reset=1 is ignored.

## Configuration

- `FETCH_RAS_EN` defined:
  - Call/Ret, the RAS_DEPTH x PC_W return stack and Ras_err are implemented.
- `FETCH_RAS_EN` undefined:
  - Call and Ret are ignored (treated as 0).
  - No stack storage exists.
  - Ras_err is tied 0.
  - Priority list collapses to 1, 2, 3, 6, 7, 8.

## Structure

- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t`;
  - `PROG_START`/`PROG_END` constant arrays, defaults {66, 299, 609} / {299, 609, 772};
  - `MAX_PROGS = 8`.
- Sub-module `ret_stack`: push/pop circular LIFO with full/empty and error outputs. It is instantiated only under `FETCH_RAS_EN`.

## Test plan

- Reset, Start: PC=66 next cycle. Free run with no branches reaches PC=299, then DONE=1 a cycle later and Prog_idx=1. Start again: PC=299, DONE=0.
- PC=100, Branch_rel_nz=1, ALU_zero=0, Target=16'hFFF6: PC=90. Same with ALU_zero=1: PC=101. Branch_abs and Branch_rel_z together, Target=200: PC=200.
- Stall=1 with Branch_abs=1 at PC=120: PC stays 120. Stall released: PC=121.
- Run all three programs: All_done=1 after PC=772. Further Start pulses leave PC=772 and the state HALT.
- RAS build, RAS_DEPTH=4: Call at PC=70 with Target=400 gives PC=400, then Ret gives PC=71. 5 nested Calls set Ras_err=1. Ret on an empty stack at PC=80 gives PC=81 and Ras_err=1.
- Reset asserted at PC=350 mid-program: next cycle PC=0, IDLE, Prog_idx=0, DONE=0, Ras_err=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and program address map for fetch_seq.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_t;
    localparam int MAX_PROGS = 8;
    localparam int unsigned PROG_START [MAX_PROGS] = '{66, 299, 609, 0, 0, 0, 0, 0};
    localparam int unsigned PROG_END   [MAX_PROGS] = '{299, 609, 772, 0, 0, 0, 0, 0};
endpackage

// File: rtl/ret_stack.sv
// ret_stack: circular LIFO of return addresses; a push when full drops the oldest
// entry and a pop when empty leaves the pointer alone, both raising a sticky err.
module ret_stack
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty,
    output logic         err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign top   = mem[ptr - PW'(1)];
    always_ff @(posedge clk) begin
        if (push && !rst) mem[ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (full) err <= 1'b1;
            else cnt <= cnt + CW'(1);
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else begin
                ptr <= ptr - PW'(1);
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: multi-program PC sequencer with absolute/relative branches and stall.
// Define FETCH_RAS_EN to build the Call/Ret hardware return stack.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int PC_W = 16,
    parameter int NUM_PROGS = 3,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic                           Stall,
    input  logic                           Branch_abs,
    input  logic                           Branch_rel_z,
    input  logic                           Branch_rel_nz,
    input  logic                           ALU_zero,
    input  logic                           Call,
    input  logic                           Ret,
    input  logic [PC_W-1:0]                Target,
    output logic [PC_W-1:0]                PC,
    output logic                           DONE,
    output logic                           All_done,
    output logic [$clog2(NUM_PROGS+1)-1:0] Prog_idx,
    output logic                           Ras_err
);
    localparam int IW = $clog2(NUM_PROGS + 1);
    fetch_state_t    state;
    logic [2:0]      sel;
    logic [PC_W-1:0] prog_start, prog_end, pc_inc, pc_rel, pc_next, ras_top;
    logic            run, at_end, advance, take_rel, call_en, ret_en, ras_empty;
    assign sel        = 3'(Prog_idx);
    assign prog_start = PC_W'(PROG_START[sel]);
    assign prog_end   = PC_W'(PROG_END[sel]);
    assign run        = state == RUN;
    assign at_end     = run && PC == prog_end;
    assign advance    = run && !at_end && !Stall;
    assign pc_inc     = PC + PC_W'(1);
    assign pc_rel     = PC + Target;
    assign take_rel   = (Branch_rel_z && ALU_zero) || (Branch_rel_nz && !ALU_zero);
    assign pc_next    = Branch_abs ? Target :
                        call_en    ? Target :
                        ret_en     ? (ras_empty ? pc_inc : ras_top) :
                        take_rel   ? pc_rel : pc_inc;
`ifdef FETCH_RAS_EN
    logic ras_full, unused_ras;
    assign call_en = Call;
    assign ret_en  = Ret;
    // Stack only moves on cycles where the PC actually takes the call/ret path
    ret_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk   (CLK),
        .rst   (Reset),
        .push  (advance && !Branch_abs && Call),
        .pop   (advance && !Branch_abs && !Call && Ret),
        .din   (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty),
        .err   (Ras_err)
    );
    assign unused_ras = ras_full;
`else
    logic unused_ras;
    assign call_en    = 1'b0;
    assign ret_en     = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign Ras_err    = 1'b0;
    assign unused_ras = ^{Call, Ret};
`endif
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            PC       <= '0;
            DONE     <= 1'b0;
            All_done <= 1'b0;
            Prog_idx <= '0;
        end else if (run) begin
            if (at_end) begin
                state    <= HALT;
                DONE     <= 1'b1;
                Prog_idx <= Prog_idx + IW'(1);
                All_done <= Prog_idx + IW'(1) == IW'(NUM_PROGS);
            end else if (advance) PC <= pc_next;
        end else if (Start && Prog_idx < IW'(NUM_PROGS)) begin
            state <= RUN;
            PC    <= prog_start;
            DONE  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: scoreboard bench for fetch_seq; a reference model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_fetch_seq;
`ifdef FETCH_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    typedef struct {
        logic [15:0] pc;
        logic        done;
        logic        all;
        logic [1:0]  idx;
        logic        err;
    } exp_t;

    logic        CLK = 0, Reset = 0, Start = 0, Stall = 0, Branch_abs = 0;
    logic        Branch_rel_z = 0, Branch_rel_nz = 0, ALU_zero = 0, Call = 0, Ret = 0;
    logic [15:0] Target = 0;
    logic [15:0] PC;
    logic        DONE, All_done, Ras_err;
    logic [1:0]  Prog_idx;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0;

    logic [15:0] p_start [3] = '{16'd66, 16'd299, 16'd609};
    logic [15:0] p_end   [3] = '{16'd299, 16'd609, 16'd772};
    int          m_state = 0, m_idx = 0, m_sp = 0, m_cnt = 0;
    logic [15:0] m_pc = 0;
    logic        m_done = 0, m_all = 0, m_err = 0;
    logic [15:0] m_stk [4];

    fetch_seq dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Stall(Stall),
        .Branch_abs(Branch_abs), .Branch_rel_z(Branch_rel_z),
        .Branch_rel_nz(Branch_rel_nz), .ALU_zero(ALU_zero),
        .Call(Call), .Ret(Ret), .Target(Target), .PC(PC), .DONE(DONE),
        .All_done(All_done), .Prog_idx(Prog_idx), .Ras_err(Ras_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        Start = 0; Stall = 0; Branch_abs = 0; Branch_rel_z = 0;
        Branch_rel_nz = 0; ALU_zero = 0; Call = 0; Ret = 0; Target = 0;
    endtask

    // Reference model: states 0=idle, 1=run, 2=halt
    task automatic model_edge();
        if (Reset) begin
            m_state = 0; m_pc = 0; m_done = 0; m_all = 0; m_idx = 0;
            m_sp = 0; m_cnt = 0; m_err = 0;
        end else if (m_state == 1) begin
            if (m_pc == p_end[m_idx]) begin
                m_done = 1; m_idx++; m_all = (m_idx == 3); m_state = 2;
            end else if (!Stall) begin
                if (Branch_abs) m_pc = Target;
                else if (RAS && Call) begin
                    m_stk[m_sp] = m_pc + 16'd1;
                    m_sp = (m_sp + 1) % 4;
                    if (m_cnt == 4) m_err = 1; else m_cnt++;
                    m_pc = Target;
                end else if (RAS && Ret) begin
                    if (m_cnt == 0) begin
                        m_err = 1; m_pc = m_pc + 16'd1;
                    end else begin
                        m_sp = (m_sp + 3) % 4; m_cnt--; m_pc = m_stk[m_sp];
                    end
                end else if ((Branch_rel_z && ALU_zero) || (Branch_rel_nz && !ALU_zero))
                    m_pc = m_pc + Target;
                else m_pc = m_pc + 16'd1;
            end
        end else if (Start && m_idx < 3) begin
            m_pc = p_start[m_idx]; m_done = 0; m_state = 1;
        end
    endtask

    task automatic step();
        exp_t e, g;
        model_edge();
        e.pc = m_pc; e.done = m_done; e.all = m_all; e.idx = 2'(m_idx); e.err = m_err;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        g = exp_q.pop_front();
        chk("pc", PC, g.pc);
        chk("done", DONE, g.done);
        chk("all_done", All_done, g.all);
        chk("prog_idx", Prog_idx, g.idx);
        chk("ras_err", Ras_err, g.err);
    endtask

    task automatic run_to(input logic [15:0] t, input int budget);
        int n = 0;
        while (PC != t && n < budget) begin
            step();
            n++;
        end
        chk("reach_pc", PC, t);
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("reach_done", DONE, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        Reset = 1; step(); step(); Reset = 0;
        chk("rst_pc", PC, 0);
        chk("rst_idx", Prog_idx, 0);
        Start = 1; step(); Start = 0;
        chk("start_pc", PC, 66);
        run_to(100, 100);
        Branch_rel_nz = 1; Target = 16'hFFF6; step(); clr();
        chk("rel_nz_taken", PC, 90);
        run_to(100, 50);
        Branch_rel_nz = 1; ALU_zero = 1; Target = 16'hFFF6; step(); clr();
        chk("rel_nz_not_taken", PC, 101);
        run_to(120, 50);
        Stall = 1; Branch_abs = 1; Target = 16'd500; step(); clr();
        chk("stall_hold", PC, 120);
        step();
        chk("stall_release", PC, 121);
        Branch_abs = 1; Branch_rel_z = 1; ALU_zero = 1; Target = 16'd200; step(); clr();
        chk("abs_priority", PC, 200);
        run_to(299, 200);
        chk("done_before_end", DONE, 0);
        step();
        chk("done_after_end", DONE, 1);
        chk("idx_after_end", Prog_idx, 1);
        chk("pc_held", PC, 299);
        Start = 1; step(); Start = 0;
        chk("prog1_pc", PC, 299);
        chk("prog1_done", DONE, 0);
        run_to(350, 100);
        Reset = 1; Start = 1; step(); Reset = 0; Start = 0;
        chk("rst_mid_pc", PC, 0);
        chk("rst_mid_idx", Prog_idx, 0);
        chk("rst_mid_done", DONE, 0);
        step();
        chk("rst_start_ignored", PC, 0);

        Start = 1; step(); Start = 0;
        run_to(70, 50);
        Call = 1; Target = 16'd400; step(); clr();
        chk("call_pc", PC, RAS ? 400 : 71);
        Ret = 1; step(); clr();
        chk("ret_pc", PC, RAS ? 71 : 72);
        for (int i = 0; i < 5; i++) begin
            Call = 1; Target = 16'(400 + 10 * i); step();
            chk("nest_err", Ras_err, RAS && i == 4);
        end
        clr();
        Branch_abs = 1; Target = 16'hFFFF; step(); clr();
        chk("abs_ffff", PC, 16'hFFFF);
        step();
        chk("wrap_pc", PC, 0);
        Reset = 1; step(); Reset = 0;
        chk("rst_err", Ras_err, 0);
        Start = 1; step(); Start = 0;
        run_to(80, 50);
        Ret = 1; step(); clr();
        chk("ret_empty_pc", PC, 81);
        chk("ret_empty_err", Ras_err, RAS);

        Reset = 1; step(); Reset = 0;
        for (int p = 0; p < 3; p++) begin
            Start = 1; step();
            if (p != 1) Start = 0;
            chk("prog_start", PC, p_start[p]);
            run_done(1000);
            Start = 0;
            chk("prog_idx_end", Prog_idx, p + 1);
        end
        chk("all_done", All_done, 1);
        chk("final_pc", PC, 772);
        repeat (3) begin
            Start = 1; step(); Start = 0; step();
            chk("halt_pc", PC, 772);
            chk("halt_all_done", All_done, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
